// File: rtl/digct_arbiter_pkg.sv
// Shared definitions for the DigCt arbiter slice.
// Holds the FSM state encoding, the cell vector/result widths, the bit
// positions of IN1..IN5 / OUT1..OUT3, and a reference model of the cell's
// logic function.
package digct_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int VEC_W = 5;
  localparam int RES_W = 3;

  localparam int IN1_B = 0;
  localparam int IN2_B = 1;
  localparam int IN3_B = 2;
  localparam int IN4_B = 3;
  localparam int IN5_B = 4;

  localparam int OUT1_B = 0;
  localparam int OUT2_B = 1;
  localparam int OUT3_B = 2;

  // Combinational view of the cell: 5-bit vector in, 3-bit result out.
  function automatic logic [RES_W-1:0] digct_ref(input logic [VEC_W-1:0] v);
    logic [RES_W-1:0] r;
    r[OUT1_B] = ~(~(v[IN1_B] | v[IN2_B]) & v[IN3_B]);
    r[OUT2_B] = ~(v[IN2_B] & v[IN3_B]);
    r[OUT3_B] = v[IN3_B] | ~v[IN4_B] | v[IN5_B];
    return r;
  endfunction

endpackage

// File: rtl/digct_arbiter_if.sv
// Requester-side bus of the DigCt arbiter.
// Handshake: a requester raises REQ[i] with its VEC slice and holds both
// stable until it sees ACK[i] (one cycle). RES_VLD is the valid strobe for
// RES/RES_ID and is high exactly in the ACK cycle; there is no ready/back
// pressure on the result side, the requester must take it that cycle.
//   master : requester agents (drive REQ, VEC)
//   slave  : the arbiter (drives ACK, RES, RES_VLD, RES_ID, BUSY, TXN_CNT,
//            dbg_state)
interface digct_arbiter_if
  import digct_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 3,
  parameter int CNTW = 8
);
  logic [NREQ-1:0]       REQ;
  logic [NREQ*VEC_W-1:0] VEC;
  logic [NREQ-1:0]       ACK;
  logic [RES_W-1:0]      RES;
  logic                  RES_VLD;
  logic [IDW-1:0]        RES_ID;
  logic                  BUSY;
  logic [CNTW-1:0]       TXN_CNT;
  state_t                dbg_state;

  modport master (
    output REQ, VEC,
    input  ACK, RES, RES_VLD, RES_ID, BUSY, TXN_CNT, dbg_state
  );

  modport slave (
    input  REQ, VEC,
    output ACK, RES, RES_VLD, RES_ID, BUSY, TXN_CNT, dbg_state
  );
endinterface

// File: rtl/digct_cell.sv
// DigCt logic cell: 5 inputs, 3 registered outputs.
// Ports: CLK; IN1..IN5 data inputs; OUT1..OUT3 registered results.
// The output register has no reset; its contents are meaningless until
// inputs have been stable for one rising edge.
module digct_cell (
  input  logic CLK,
  input  logic IN1,
  input  logic IN2,
  input  logic IN3,
  input  logic IN4,
  input  logic IN5,
  output logic OUT1,
  output logic OUT2,
  output logic OUT3
);
  always_ff @(posedge CLK) begin
    OUT1 <= ~(~(IN1 | IN2) & IN3);
    OUT2 <= ~(IN2 & IN3);
    OUT3 <= IN3 | ~IN4 | IN5;
  end
endmodule

// File: rtl/digct_rr_pick.sv
// Combinational round-robin picker.
// Ports: req (per-requester request), ptr (highest-priority index);
// win (first requester with req high at or above ptr, wrapping),
// any (at least one request present; win is 0 when any is low).
module digct_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  win,
  output logic            any
);
  int idx;

  // Scan offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        win = IDW'(idx);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/digct_arbiter.sv
// Round-robin arbiter sharing one DigCt cell among NREQ requesters.
// Ports: CLK, RST (synchronous, active-high); bus (slave modport) carrying
// REQ/VEC in and ACK/RES/RES_VLD/RES_ID/BUSY/TXN_CNT/dbg_state out.
// Each transaction walks IDLE -> ISSUE -> CAPTURE -> DONE, one cycle each.
module digct_arbiter
  import digct_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 3,
  parameter int CNTW = 8
) (
  input  logic            CLK,
  input  logic            RST,
  digct_arbiter_if.slave  bus
);
  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, win_q, res_id_q, pick_win;
  logic             pick_any;
  logic [VEC_W-1:0] cell_in_q;
  logic [RES_W-1:0] cell_out, res_q;
  logic [CNTW-1:0]  cnt_q;
  logic [NREQ-1:0]  ack_c;

  digct_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req (bus.REQ),
    .ptr (ptr_q),
    .win (pick_win),
    .any (pick_any)
  );

  digct_cell u_cell (
    .CLK  (CLK),
    .IN1  (cell_in_q[IN1_B]),
    .IN2  (cell_in_q[IN2_B]),
    .IN3  (cell_in_q[IN3_B]),
    .IN4  (cell_in_q[IN4_B]),
    .IN5  (cell_in_q[IN5_B]),
    .OUT1 (cell_out[OUT1_B]),
    .OUT2 (cell_out[OUT2_B]),
    .OUT3 (cell_out[OUT3_B])
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = ISSUE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      cell_in_q <= '0;
      res_q     <= '0;
      res_id_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            cell_in_q <= bus.VEC[int'(pick_win)*VEC_W +: VEC_W];
            win_q     <= pick_win;
            ptr_q     <= (int'(pick_win) == NREQ - 1) ? '0 : pick_win + IDW'(1);
          end
        end
        // Cell output register was loaded at the end of ISSUE.
        CAPTURE: begin
          res_q    <= cell_out;
          res_id_q <= win_q;
        end
        DONE:    cnt_q <= cnt_q + CNTW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    ack_c = '0;
    if (state_q == DONE) ack_c[win_q] = 1'b1;
  end

  assign bus.ACK       = ack_c;
  assign bus.RES       = res_q;
  assign bus.RES_VLD   = (state_q == DONE);
  assign bus.RES_ID    = res_id_q;
  assign bus.BUSY      = (state_q != IDLE);
  assign bus.TXN_CNT   = cnt_q;
  assign bus.dbg_state = state_q;
endmodule
